// File: rtl/ro_sched_mux.sv
// ---------------------------------------------------------------------------
// ro_sched_mux
//
// Time-division readout multiplexer. A free-running binary slot counter b
// (exported as Gray code) hands out one service slot per enabled cycle. The
// slot number is the count of trailing ones of b, which is exactly the Gray
// bit that toggles on the next increment. Channel i therefore owns one slot
// every 2^(i+1) enabled cycles; slots >= N_CH are idle.
//
// Each channel keeps a pending flag, the polarity of its latest event and an
// overflow flag (an event arrived while an earlier one was still pending).
// On a serviced slot the channel's registers are reported on the serial
// outputs one cycle later and the pending/overflow flags are cleared.
//
// Optional feature (compile-time macro RO_EDGE_DETECT_EN):
//   defined   : an event is captured only on a 0->1 transition of in_eve[i]
//               relative to a registered copy of in_eve (cleared by reset).
//   undefined : an event is captured on every cycle in which in_eve[i]=1.
//
// Parameters
//   N_CH   : number of readout channels (1..16)
//   CNT_W  : slot counter width, CNT_W >= N_CH
//
// Ports
//   clk_master      in   1       single clock, rising edge
//   reset           in   1       synchronous active-high reset
//   en              in   1       slot counter advance enable
//   in_eve          in   N_CH    per-channel event request
//   in_pol_eve      in   N_CH    per-channel event polarity (sampled with in_eve)
//   gray            out  CNT_W   Gray code of the slot counter
//   out_mux_eve     out  1       event bit of the serviced channel
//   out_mux_pol_eve out  1       polarity of the serviced channel
//   out_valid       out  1       output slot belongs to a channel
//   out_ch          out  CH_W    index of the serviced channel
//   out_ovf         out  1       serviced channel lost one or more events
// ---------------------------------------------------------------------------
module ro_sched_mux #(
    parameter  int N_CH  = 8,
    parameter  int CNT_W = 8,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int S_W   = $clog2(CNT_W + 1)
) (
    input  logic              clk_master,
    input  logic              reset,
    input  logic              en,
    input  logic [N_CH-1:0]   in_eve,
    input  logic [N_CH-1:0]   in_pol_eve,
    output logic [CNT_W-1:0]  gray,
    output logic              out_mux_eve,
    output logic              out_mux_pol_eve,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_ovf
);

    logic [CNT_W-1:0] b_reg;
    logic [CNT_W-1:0] b_next;

    logic [N_CH-1:0]  pend_reg, pend_next;
    logic [N_CH-1:0]  pol_reg,  pol_next;
    logic [N_CH-1:0]  ovf_reg,  ovf_next;

    logic [N_CH-1:0]  cap;       // event captured this cycle, per channel
    logic [N_CH-1:0]  svc_vec;   // one-hot: channel serviced this cycle
    logic [S_W-1:0]   slot;      // trailing-ones count of b_reg

    logic             eve_out_reg, eve_out_next;
    logic             pol_out_reg, pol_out_next;
    logic             valid_reg,   valid_next;
    logic [CH_W-1:0]  ch_reg,      ch_next;
    logic             ovf_out_reg, ovf_out_next;

    // -----------------------------------------------------------------------
    // Event capture
    // -----------------------------------------------------------------------
`ifdef RO_EDGE_DETECT_EN
    logic [N_CH-1:0] eve_prev_reg;

    always_ff @(posedge clk_master) begin
        if (reset) begin
            eve_prev_reg <= '0;
        end else begin
            eve_prev_reg <= in_eve;
        end
    end

    // A level held high through reset release is seen as a fresh rising
    // edge because the history register comes out of reset at 0.
    assign cap = in_eve & ~eve_prev_reg;
`else
    assign cap = in_eve;
`endif

    // -----------------------------------------------------------------------
    // Slot counter and slot decode
    // -----------------------------------------------------------------------
    assign b_next = en ? (b_reg + CNT_W'(1)) : b_reg;
    assign gray   = b_reg ^ (b_reg >> 1);

    // Lowest zero bit of b_reg; all-ones gives CNT_W (an idle slot).
    always_comb begin
        slot = S_W'(CNT_W);
        for (int i = CNT_W - 1; i >= 0; i--) begin
            if (!b_reg[i]) begin
                slot = S_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel state update
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign svc_vec[gi] = en && (slot == S_W'(gi));

            // A capture always (re)arms pending. If the channel is being
            // serviced in the same cycle the old event is reported and the
            // new one is simply kept, so no overflow is recorded.
            assign pend_next[gi] = cap[gi] | (pend_reg[gi] & ~svc_vec[gi]);
            assign pol_next[gi]  = cap[gi] ? in_pol_eve[gi] : pol_reg[gi];
            assign ovf_next[gi]  = svc_vec[gi] ? 1'b0
                                 : (ovf_reg[gi] | (cap[gi] & pend_reg[gi]));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output selection (registered, reported one cycle after the slot)
    // -----------------------------------------------------------------------
    always_comb begin
        valid_next   = |svc_vec;
        eve_out_next = |(pend_reg & svc_vec);
        pol_out_next = |(pol_reg  & svc_vec);
        ovf_out_next = |(ovf_reg  & svc_vec);
        ch_next      = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (svc_vec[i]) begin
                ch_next = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk_master) begin
        if (reset) begin
            b_reg       <= '0;
            pend_reg    <= '0;
            pol_reg     <= '0;
            ovf_reg     <= '0;
            eve_out_reg <= 1'b0;
            pol_out_reg <= 1'b0;
            valid_reg   <= 1'b0;
            ch_reg      <= '0;
            ovf_out_reg <= 1'b0;
        end else begin
            b_reg       <= b_next;
            pend_reg    <= pend_next;
            pol_reg     <= pol_next;
            ovf_reg     <= ovf_next;
            eve_out_reg <= eve_out_next;
            pol_out_reg <= pol_out_next;
            valid_reg   <= valid_next;
            ch_reg      <= ch_next;
            ovf_out_reg <= ovf_out_next;
        end
    end

    assign out_mux_eve     = eve_out_reg;
    assign out_mux_pol_eve = pol_out_reg;
    assign out_valid       = valid_reg;
    assign out_ch          = ch_reg;
    assign out_ovf         = ovf_out_reg;

endmodule

// File: tb/tb_ro_sched_mux.sv
// ---------------------------------------------------------------------------
// tb_ro_sched_mux
//
// Scoreboard bench for ro_sched_mux (N_CH=8, CNT_W=8). The stimulus process
// drives one cycle at a time, predicts the registered outputs for that edge
// with a small behavioural model and, at selected slots, attaches a
// hand-computed expectation. The entry is queued after the edge; a separate
// monitor pops one entry per cycle at the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_ro_sched_mux;

    localparam int N_CH  = 8;
    localparam int CNT_W = 8;

`ifdef RO_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic        clk_master = 1'b0;
    logic        reset      = 1'b1;
    logic        en         = 1'b0;
    logic [7:0]  in_eve     = '0;
    logic [7:0]  in_pol_eve = '0;
    logic [7:0]  gray;
    logic        out_mux_eve;
    logic        out_mux_pol_eve;
    logic        out_valid;
    logic [2:0]  out_ch;
    logic        out_ovf;

    ro_sched_mux #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk_master      (clk_master),
        .reset           (reset),
        .en              (en),
        .in_eve          (in_eve),
        .in_pol_eve      (in_pol_eve),
        .gray            (gray),
        .out_mux_eve     (out_mux_eve),
        .out_mux_pol_eve (out_mux_pol_eve),
        .out_valid       (out_valid),
        .out_ch          (out_ch),
        .out_ovf         (out_ovf)
    );

    always #5 clk_master = ~clk_master;

    typedef struct {
        logic [7:0] gray;
        logic       valid;
        logic [2:0] ch;
        logic       eve;
        logic       pol;
        logic       ovf;
        bit         hand;
        logic       hvalid;
        logic [2:0] hch;
        logic       heve;
        logic       hpol;
        logic       hovf;
        string      hname;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // behavioural model state
    int       m_b = 0;
    bit [7:0] m_pend = '0, m_pol = '0, m_ovf = '0, m_prev = '0;

    // pending hand-computed expectation for the next step
    bit         h_set = 1'b0;
    string      h_name = "";
    logic       h_valid, h_eve, h_pol, h_ovf;
    logic [2:0] h_ch;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d: got %0h, expected %0h", nm, txn, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk_master);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                txn++;
                $display("txn %0d: gray=%02h valid=%0b ch=%0d eve=%0b pol=%0b ovf=%0b%s",
                         txn, gray, out_valid, out_ch, out_mux_eve, out_mux_pol_eve,
                         out_ovf, x.hand ? {" [", x.hname, "]"} : "");
                chk("gray",  gray,                   x.gray);
                chk("valid", {7'd0, out_valid},       {7'd0, x.valid});
                chk("ch",    {5'd0, out_ch},          {5'd0, x.ch});
                chk("eve",   {7'd0, out_mux_eve},     {7'd0, x.eve});
                chk("pol",   {7'd0, out_mux_pol_eve}, {7'd0, x.pol});
                chk("ovf",   {7'd0, out_ovf},         {7'd0, x.ovf});
                if (x.hand) begin
                    chk({x.hname, ".valid"}, {7'd0, out_valid},       {7'd0, x.hvalid});
                    chk({x.hname, ".ch"},    {5'd0, out_ch},          {5'd0, x.hch});
                    chk({x.hname, ".eve"},   {7'd0, out_mux_eve},     {7'd0, x.heve});
                    chk({x.hname, ".pol"},   {7'd0, out_mux_pol_eve}, {7'd0, x.hpol});
                    chk({x.hname, ".ovf"},   {7'd0, out_ovf},         {7'd0, x.hovf});
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic hand(input string nm, input logic v, input logic [2:0] c,
                        input logic e, input logic p, input logic o);
        h_set = 1'b1; h_name = nm;
        h_valid = v; h_ch = c; h_eve = e; h_pol = p; h_ovf = o;
    endtask

    task automatic step(input bit rst, input bit en_i,
                        input logic [7:0] eve_i, input logic [7:0] pol_i);
        exp_t     x;
        int       s;
        bit       svc;
        bit [7:0] cap;
        reset = rst; en = en_i; in_eve = eve_i; in_pol_eve = pol_i;
        x.valid = 1'b0; x.ch = '0; x.eve = 1'b0; x.pol = 1'b0; x.ovf = 1'b0;
        if (rst) begin
            m_b = 0; m_pend = '0; m_pol = '0; m_ovf = '0; m_prev = '0;
        end else begin
            cap = EDGE ? (eve_i & ~m_prev) : eve_i;
            m_prev = eve_i;
            s = 0;
            while (s < CNT_W && ((m_b >> s) & 1) == 1) s++;
            svc = en_i && (s < N_CH);
            if (svc) begin
                x.valid = 1'b1; x.ch = 3'(s);
                x.eve = m_pend[s]; x.pol = m_pol[s]; x.ovf = m_ovf[s];
            end
            for (int i = 0; i < N_CH; i++) begin
                if (svc && s == i) begin
                    m_pend[i] = cap[i];
                    m_ovf[i]  = 1'b0;
                end else if (cap[i]) begin
                    if (m_pend[i]) m_ovf[i] = 1'b1;
                    m_pend[i] = 1'b1;
                end
                if (cap[i]) m_pol[i] = pol_i[i];
            end
            if (en_i) m_b = (m_b + 1) % 256;
        end
        x.gray = 8'(m_b ^ (m_b >> 1));
        x.hand = h_set; x.hname = h_name;
        x.hvalid = h_valid; x.hch = h_ch; x.heve = h_eve; x.hpol = h_pol; x.hovf = h_ovf;
        h_set = 1'b0;
        @(posedge clk_master);
        exp_q.push_back(x);
        #1;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (m_b != target && guard < 300) begin
            step(0, 1, 8'h00, 8'h00);
            guard++;
        end
    endtask

    task automatic do_reset();
        hand("reset", 0, 0, 0, 0, 0);
        step(1, 1, 8'hff, 8'hff);
        step(1, 0, 8'h00, 8'h00);
    endtask

    int seq[8] = '{0, 1, 0, 2, 0, 1, 0, 3};

    initial begin
        // reset with en and events active, then plain slot sequence
        do_reset();
        for (int k = 0; k < 8; k++) begin
            hand("seq", 1, 3'(seq[k]), 0, 0, 0);
            step(0, 1, 8'h00, 8'h00);
        end
        run_to(255);
        hand("idle_all_ones", 0, 0, 0, 0, 0);
        step(0, 1, 8'h00, 8'h00);
        hand("wrap_ch0", 1, 0, 0, 0, 0);
        step(0, 1, 8'h00, 8'h00);

        // capture on ch0 during ch0's own slot: reported at the next ch0 slot
        do_reset();
        hand("ch0_same_slot", 1, 0, 0, 0, 0);
        step(0, 1, 8'h01, 8'h01);
        step(0, 1, 8'h00, 8'h00);
        hand("ch0_next_slot", 1, 0, 1, 1, 0);
        step(0, 1, 8'h00, 8'h00);

        // single event on ch3 (slots at b=7, 23, ...)
        do_reset();
        run_to(2);
        step(0, 1, 8'h08, 8'h08);
        run_to(7);
        hand("ch3_event", 1, 3, 1, 1, 0);
        step(0, 1, 8'h00, 8'h00);
        run_to(23);
        hand("ch3_empty", 1, 3, 0, 1, 0);
        step(0, 1, 8'h00, 8'h00);

        // two events on ch5 before its slot: last polarity wins, overflow set
        do_reset();
        run_to(1);
        step(0, 1, 8'h20, 8'h00);
        run_to(4);
        step(0, 1, 8'h20, 8'h20);
        run_to(31);
        hand("ch5_ovf", 1, 5, 1, 1, 1);
        step(0, 1, 8'h00, 8'h00);
        run_to(95);
        hand("ch5_cleared", 1, 5, 0, 1, 0);
        step(0, 1, 8'h00, 8'h00);

        // ch1 held high for 10 cycles (ch1 slots at b=1, 5, 9)
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k == 1) hand("hold_b1", 1, 1, 1, 0, 0);
            if (k == 5) hand("hold_b5", 1, 1, EDGE ? 1'b0 : 1'b1, 0, EDGE ? 1'b0 : 1'b1);
            step(0, 1, 8'h02, 8'h00);
        end
        // en=0: outputs idle, capture still works (ch4 slot at b=15)
        hand("en0_idle", 0, 0, 0, 0, 0);
        step(0, 0, 8'h10, 8'h10);
        step(0, 0, 8'h00, 8'h00);
        hand("en0_hold", 0, 0, 0, 0, 0);
        step(0, 0, 8'h00, 8'h00);
        run_to(15);
        hand("en0_capture", 1, 4, 1, 1, 0);
        step(0, 1, 8'h00, 8'h00);

        // events pending on ch2 and ch6, then reset mid-run
        do_reset();
        run_to(10);
        step(0, 1, 8'h40, 8'h40);
        run_to(36);
        step(0, 1, 8'h04, 8'h04);
        run_to(40);
        hand("mid_reset", 0, 0, 0, 0, 0);
        step(1, 1, 8'h04, 8'h04);
        hand("post_reset_ch0", 1, 0, 0, 0, 0);
        step(0, 1, 8'h04, 8'h04);   // ch2 held through reset release
        step(0, 1, 8'h00, 8'h00);
        step(0, 1, 8'h00, 8'h00);
        hand("held_through_reset", 1, 2, 1, 1, 0);
        step(0, 1, 8'h00, 8'h00);
        run_to(63);
        hand("ch6_discarded", 1, 6, 0, 0, 0);
        step(0, 1, 8'h00, 8'h00);

        // pseudo-random traffic checked against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom & $urandom & $urandom), 8'($urandom));
        end

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk_master);
        @(negedge clk_master);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
